// File: rtl/enable_prescaler_pkg.sv
// Shared definitions for the enable prescaler: state encoding, default
// widths and the minimum effective divide ratio.
package enable_prescaler_pkg;

  localparam int DIV_WIDTH_DEF   = 8;
  localparam int BURST_WIDTH_DEF = 4;
  localparam int DIV_MIN         = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/prescale_divider.sv
// Prescale divider: latches the divide ratio on load and runs the prescale
// counter. tick_o reports, one cycle early, that the counter will sit at
// div_l-1 in the next cycle, so the parent can register its strobe and still
// land the first pulse exactly div_l cycles after the load edge.
module prescale_divider
  import enable_prescaler_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 advance_i,
  input  logic [DIV_WIDTH-1:0] div_ratio_i,
  output logic                 tick_o
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(DIV_MIN);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

  // Next ratio/count: load clears and latches (0 counts as 1), advance wraps at div_l-1.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (load_i) begin
      div_d = (div_ratio_i == '0) ? DIV_ONE : div_ratio_i;
      cnt_d = '0;
    end else if (advance_i) begin
      cnt_d = (cnt_q == div_q - DIV_ONE) ? '0 : cnt_q + DIV_ONE;
    end
  end

  assign tick_o = (cnt_d == div_d - DIV_ONE);

  // Ratio and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q <= DIV_ONE;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/enable_prescaler.sv
// Enable prescaler top: IDLE/RUN sequencer producing single-cycle count
// enables every div_l cycles, either continuously or for a burst of burst_l
// pulses, with busy/done status.
// Optional pause input is built in when ENABLE_PRESCALER_PAUSE_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; enable_out and busy low
// RUN   | dividing clk and emitting enable pulses; busy high
module enable_prescaler
  import enable_prescaler_pkg::*;
#(
  parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   stop,
`ifdef ENABLE_PRESCALER_PAUSE_EN
  input  logic                   pause,
`endif
  input  logic [DIV_WIDTH-1:0]   div_ratio,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   enable_out,
  output logic                   busy,
  output logic                   done
);

  localparam logic [BURST_WIDTH-1:0] BURST_ONE = BURST_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [BURST_WIDTH-1:0] burst_q, burst_d;
  logic [BURST_WIDTH-1:0] pulse_q, pulse_d;
  logic [BURST_WIDTH-1:0] pulse_inc;
  logic                   enable_q, enable_d;
  logic                   done_q, done_d;
  logic                   load, advance, tick, pause_w;

`ifdef ENABLE_PRESCALER_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign pulse_inc = pulse_q + BURST_ONE;

  prescale_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .advance_i   (advance),
    .div_ratio_i (div_ratio),
    .tick_o      (tick)
  );

  // Next state, burst bookkeeping and the registered enable/done strobes.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    pulse_d = pulse_q;
    done_d  = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = RUN;
          load    = 1'b1;
          burst_d = burst_len;
          pulse_d = '0;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          advance = !pause_w;
          if (enable_q) begin
            pulse_d = pulse_inc;
            if ((burst_q != '0) && (pulse_inc == burst_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    enable_d = (state_d == RUN) && tick && (load || advance);
  end

  // State and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      burst_q  <= '0;
      pulse_q  <= '0;
      enable_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      pulse_q  <= pulse_d;
      enable_q <= enable_d;
      done_q   <= done_d;
    end
  end

  assign enable_out = enable_q;
  assign busy       = (state_q == RUN);
  assign done       = done_q;

endmodule

// File: tb/tb_enable_prescaler.sv
// Directed testbench for enable_prescaler. Cycle j of a run is the clock
// period following the j-th edge after the start edge (j=1 is the first busy
// cycle). Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_enable_prescaler;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
`ifdef ENABLE_PRESCALER_PAUSE_EN
  logic       pause;
`endif
  logic [7:0] div_ratio;
  logic [3:0] burst_len;
  logic       enable_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  enable_prescaler dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
`ifdef ENABLE_PRESCALER_PAUSE_EN
    .pause      (pause),
`endif
    .div_ratio  (div_ratio),
    .burst_len  (burst_len),
    .enable_out (enable_out),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start in IDLE; returns positioned at cycle j=1.
  task automatic kick(input logic [7:0] div, input logic [3:0] len);
    div_ratio = div;
    burst_len = len;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++;
    if (enable_out !== 1'b0) begin n_fail++; $display("FAIL reset_en got=%b exp=0", enable_out); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    reset = 1'b1;
    tick();
    // reset mid-burst
    kick(8'd4, 4'd5);
    for (int j = 1; j < 7; j++) tick();
    reset = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    n_checks++;
    if ({enable_out, busy, done} !== 3'b000)
      begin n_fail++; $display("FAIL reset_mid got=%b exp=000", {enable_out, busy, done}); end
    for (int j = 0; j < 25; j++) begin
      tick();
      n_checks++;
      if ({enable_out, busy, done} !== 3'b000)
        begin n_fail++; $display("FAIL reset_quiet c=%0d got=%b exp=000", j, {enable_out, busy, done}); end
    end
  endtask

  task automatic test_burst();
    kick(8'd3, 4'd4);
    for (int j = 1; j <= 15; j++) begin
      n_checks++;
      if (enable_out !== ((j % 3 == 0) && (j <= 12)))
        begin n_fail++; $display("FAIL burst_en j=%0d got=%b", j, enable_out); end
      n_checks++;
      if (busy !== (j <= 12)) begin n_fail++; $display("FAIL burst_busy j=%0d got=%b", j, busy); end
      n_checks++;
      if (done !== (j == 13)) begin n_fail++; $display("FAIL burst_done j=%0d got=%b", j, done); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    kick(8'd0, 4'd2);
    for (int j = 1; j <= 5; j++) begin
      n_checks++;
      if (enable_out !== (j <= 2)) begin n_fail++; $display("FAIL div0_en j=%0d got=%b", j, enable_out); end
      n_checks++;
      if (busy !== (j <= 2)) begin n_fail++; $display("FAIL div0_busy j=%0d got=%b", j, busy); end
      n_checks++;
      if (done !== (j == 3)) begin n_fail++; $display("FAIL div0_done j=%0d got=%b", j, done); end
      tick();
    end
  endtask

  task automatic test_stop();
    kick(8'd2, 4'd0);
    for (int j = 1; j <= 11; j++) begin
      n_checks++;
      if (enable_out !== ((j % 2 == 0) && (j <= 6)))
        begin n_fail++; $display("FAIL stop_en j=%0d got=%b", j, enable_out); end
      n_checks++;
      if (busy !== (j <= 7)) begin n_fail++; $display("FAIL stop_busy j=%0d got=%b", j, busy); end
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL stop_done j=%0d got=%b exp=0", j, done); end
      stop = (j == 7);
      tick();
    end
    stop = 1'b0;
  endtask

  task automatic test_continuous_wrap();
    kick(8'd1, 4'd0);
    for (int j = 1; j <= 40; j++) begin
      n_checks++;
      if ({enable_out, busy, done} !== 3'b110)
        begin n_fail++; $display("FAIL cont_wrap j=%0d got=%b exp=110", j, {enable_out, busy, done}); end
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({enable_out, busy, done} !== 3'b000)
      begin n_fail++; $display("FAIL cont_stop got=%b exp=000", {enable_out, busy, done}); end
  endtask

  task automatic test_start_stop_and_changes();
    div_ratio = 8'd1;
    burst_len = 4'd1;
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    for (int j = 0; j < 3; j++) begin
      n_checks++;
      if ({enable_out, busy, done} !== 3'b000)
        begin n_fail++; $display("FAIL start_stop c=%0d got=%b exp=000", j, {enable_out, busy, done}); end
      tick();
    end
    // start and new settings while running are ignored
    kick(8'd2, 4'd3);
    for (int j = 1; j <= 9; j++) begin
      n_checks++;
      if (enable_out !== ((j % 2 == 0) && (j <= 6)))
        begin n_fail++; $display("FAIL runchg_en j=%0d got=%b", j, enable_out); end
      n_checks++;
      if (done !== (j == 7)) begin n_fail++; $display("FAIL runchg_done j=%0d got=%b", j, done); end
      if (j == 1) begin div_ratio = 8'd9; burst_len = 4'd1; start = 1'b1; end
      if (j == 3) start = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    kick(8'd1, 4'd2);
    for (int j = 1; j <= 8; j++) begin
      n_checks++;
      if (enable_out !== (j == 1 || j == 2 || j == 5))
        begin n_fail++; $display("FAIL b2b_en j=%0d got=%b", j, enable_out); end
      n_checks++;
      if (busy !== (j == 1 || j == 2 || j == 4 || j == 5))
        begin n_fail++; $display("FAIL b2b_busy j=%0d got=%b", j, busy); end
      n_checks++;
      if (done !== (j == 3 || j == 6))
        begin n_fail++; $display("FAIL b2b_done j=%0d got=%b", j, done); end
      if (j == 3) begin div_ratio = 8'd2; burst_len = 4'd1; start = 1'b1; end
      if (j == 4) start = 1'b0;
      tick();
    end
  endtask

`ifdef ENABLE_PRESCALER_PAUSE_EN
  task automatic test_pause();
    kick(8'd2, 4'd3);
    for (int j = 1; j <= 14; j++) begin
      n_checks++;
      if (enable_out !== (j == 2 || j == 9 || j == 11))
        begin n_fail++; $display("FAIL pause_en j=%0d got=%b", j, enable_out); end
      n_checks++;
      if (busy !== (j <= 11)) begin n_fail++; $display("FAIL pause_busy j=%0d got=%b", j, busy); end
      n_checks++;
      if (done !== (j == 12)) begin n_fail++; $display("FAIL pause_done j=%0d got=%b", j, done); end
      pause = (j >= 3 && j <= 7);
      tick();
    end
    pause = 1'b0;
  endtask
`endif

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
`ifdef ENABLE_PRESCALER_PAUSE_EN
    pause     = 1'b0;
`endif
    div_ratio = 8'd0;
    burst_len = 4'd0;
    test_reset();
    test_burst();
    test_div_zero();
    test_stop();
    test_continuous_wrap();
    test_start_stop_and_changes();
    test_back_to_back();
`ifdef ENABLE_PRESCALER_PAUSE_EN
    test_pause();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
